// File: rtl/inst_encoder_if.sv
// Field-set input and instruction-memory write bus of inst_encoder.
// slave: encoder side; master: field producer / memory model side.
interface inst_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic              in_fmt;
    logic [6:0]        in_opcode;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [31:0]       in_imm;
    logic              in_last;
    logic              imem_we;
    logic              imem_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              done;
    logic              full;
    logic              err;

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
        input  in_funct3, in_funct7, in_imm, in_last, imem_ready,
        output in_ready, imem_we, imem_addr, imem_wdata,
        output done, full, err
    );

    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
        output in_funct3, in_funct7, in_imm, in_last, imem_ready,
        input  in_ready, imem_we, imem_addr, imem_wdata,
        input  done, full, err
    );
endinterface

// File: rtl/inst_encoder.sv
// RV32I R/I-type field encoder with 2-entry FIFO and imem loader.
// Ports: clk, rst_n (async low), bus (inst_encoder_if.slave).
// Option: INST_ENC_RANGE_CHECK_EN drops out-of-range immediates.
module inst_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    inst_encoder_if.slave  bus
);
    logic [31:0]       r_word [2];
    logic [1:0]        r_last;
    logic [1:0]        r_flag;
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_done;
    logic              r_full;
    logic              r_err;

    logic        w_shift;
    logic [31:0] w_word;
    logic        w_flag;
    logic        w_ready;
    logic        w_push;
    logic        w_nonempty;
    logic        w_head_flag;
    logic        w_head_last;
    logic        w_pop;

    assign w_shift = (bus.in_opcode == 7'b0010011) &&
                     ((bus.in_funct3 == 3'b001) ||
                      (bus.in_funct3 == 3'b101));

    always_comb begin
        w_word = '0;
        if (!bus.in_fmt) begin
            w_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1,
                      bus.in_funct3, bus.in_rd, bus.in_opcode};
        end else if (w_shift) begin
            w_word = {bus.in_funct7, bus.in_imm[4:0], bus.in_rs1,
                      bus.in_funct3, bus.in_rd, bus.in_opcode};
        end else begin
            w_word = {bus.in_imm[11:0], bus.in_rs1,
                      bus.in_funct3, bus.in_rd, bus.in_opcode};
        end
    end

`ifdef INST_ENC_RANGE_CHECK_EN
    // Shifts need 0..31; others need bits [31:11] to be pure sign.
    logic w_imm_bad;
    always_comb begin
        w_imm_bad = 1'b0;
        if (bus.in_fmt) begin
            if (w_shift) begin
                w_imm_bad = |bus.in_imm[31:5];
            end else begin
                w_imm_bad = !((&bus.in_imm[31:11]) ||
                              !(|bus.in_imm[31:11]));
            end
        end
    end
    assign w_flag = w_imm_bad;
`else
    // Upper immediate bits are simply truncated away.
    logic w_unused_imm;
    assign w_unused_imm = ^bus.in_imm[31:12];
    assign w_flag = 1'b0;
`endif

    // Registered-only flow control: no path from imem_ready.
    assign w_ready     = !r_full && (r_cnt != 2'd2);
    assign w_push      = bus.in_valid && w_ready;
    assign w_nonempty  = (r_cnt != 2'd0);
    assign w_head_flag = r_flag[r_rptr];
    assign w_head_last = r_last[r_rptr];
    // Flagged heads drain without touching memory.
    assign w_pop = w_nonempty && (w_head_flag || bus.imem_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_word[i] <= '0;
            end
            r_last <= '0;
            r_flag <= '0;
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_cnt  <= '0;
            r_addr <= '0;
            r_done <= 1'b0;
            r_full <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= w_pop && w_head_last;
            if (w_push) begin
                r_word[r_wptr] <= w_word;
                r_last[r_wptr] <= bus.in_last;
                r_flag[r_wptr] <= w_flag;
                r_wptr         <= ~r_wptr;
                if (w_flag) begin
                    r_err <= 1'b1;
                end
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
            if (w_pop) begin
                if (w_head_last) begin
                    r_addr <= '0;
                end else if (!w_head_flag) begin
                    // Last slot written without in_last: memory is full.
                    if (r_addr == {ADDR_W{1'b1}}) begin
                        r_full <= 1'b1;
                    end
                    r_addr <= r_addr + 1'b1;
                end
            end
        end
    end

    assign bus.in_ready   = w_ready;
    assign bus.imem_we    = w_nonempty && !w_head_flag;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = w_nonempty ? r_word[r_rptr] : 32'h0;
    assign bus.done       = r_done;
    assign bus.full       = r_full;
    assign bus.err        = r_err;
endmodule

// File: doc/inst_encoder.md
# inst_encoder

Instruction encoder and instruction-memory loader for the single-cycle RV32I core. It accepts decoded instruction fields (format, opcode, registers, functs, signed immediate) over a valid/ready handshake and packs them into 32-bit R-type and I-type machine words. It buffers the words in a 2-entry FIFO and writes them sequentially into instruction memory. It is the field-to-word counterpart of the core's immediate extraction and sign extension, and is used to load test programs before the core is released from reset.

## Interface
- ADDR_W, 8, instruction-memory word-address width; program capacity is 2^ADDR_W words.

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  field set valid
- in_ready  out  1  encoder can accept a field set
- in_fmt  in  1  0 = R-type, 1 = I-type
- in_opcode  in  7  opcode field, placed verbatim in bits [6:0]
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7; also the upper immediate bits for I-type shifts
- in_imm  in  32  signed immediate value (I-type only)
- in_last  in  1  marks the last instruction of a program
- imem_we  out  1  write strobe
- imem_ready  in  1  memory accepts the write this cycle
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded instruction
- done  out  1  one-cycle pulse when the in_last word completes
- full  out  1  sticky; the memory end was reached without in_last
- err  out  1  sticky immediate range error

## Operation
- **Accept:** a field set is accepted when in_valid && in_ready and is pushed into a 2-entry FIFO. Encoding happens at push, so the FIFO stores the 32-bit word plus its last and error flags.
- **R-type encoding:** {funct7, rs2, rs1, funct3, rd, opcode}.
- **I-type encoding:** {imm[11:0], rs1, funct3, rd, opcode}. Legal range is -2048..2047.
- **I-type shifts:** when opcode = 0010011 and funct3 = 001 or 101, the word is {funct7, imm[4:0], rs1, funct3, rd, opcode}. Legal range is 0..31.
- **Write:** imem_we = FIFO non-empty. imem_wdata and imem_addr present the FIFO head. A write completes when imem_we && imem_ready; the head then pops and the address increments.
- **Flagged entry:** an entry carrying the error flag pops in one cycle without asserting imem_we. The address does not advance.
- **in_last:** when the in_last entry completes (written or dropped), done pulses for 1 cycle and the address returns to 0.
- **Full:** a write to address 2^ADDR_W-1 without in_last sets full and forces in_ready = 0 until reset. A write to that address with in_last wraps to 0 and does not set full.
- **Simultaneous events:** a push and a pop in the same cycle keep the occupancy unchanged.

## Timing
- **Reset values:** in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, done=0, full=0, err=0. FIFO empty.
- **Latency:** a field set accepted in cycle N gives imem_we high in cycle N+1 (FIFO previously empty, no combinational pass-through).
- **Throughput:** 1 word/cycle when imem_ready is held high.
- **Flow control:** in_ready = !full && (occupancy < 2), driven from registers only. There is no combinational path from imem_ready to in_ready, so in_ready stays low when the FIFO is full even if a pop occurs in that cycle.
- **Output stability:** imem_addr and imem_wdata hold stable while imem_we && !imem_ready.
- **Reset mid-operation:** asserting rst_n low flushes the FIFO immediately and drops any pending write. All outputs go to their reset values asynchronously.

## Configuration
- **INST_ENC_RANGE_CHECK_EN defined:** an out-of-range immediate is flagged at push. The entry is dropped, err is set (sticky until reset), and the address is unchanged.
- **INST_ENC_RANGE_CHECK_EN undefined:** the immediate is truncated (imm[11:0], or imm[4:0] for shifts) and written normally. err is tied to 0.

## Test plan
- R-type add x3,x1,x2 (opcode 0110011, f3 0, f7 0) -> imem_wdata 0x002081B3 at addr 0, with imem_we high in the cycle after acceptance.
- I-type addi x5,x0,-1 then lw x6,8(x2) (opcode 0000011, f3 010) -> 0xFFF00293 at addr 0 and 0x00812303 at addr 1 on consecutive cycles.
- srai x7,x7,3 (f3 101, f7 0100000) -> 0x4033D393.
- addi x5,x0 with imm=2048 -> with INST_ENC_RANGE_CHECK_EN: no write, err=1, next word still written at the same addr. Without the macro: 0x80000293 written, err=0.
- imem_ready=0 with 3 pushes -> in_ready low after 2 accepts. Release imem_ready -> words appear in order at addr 0,1,2.
- in_last on the 4th word -> done pulses once and the next word lands at addr 0.
- ADDR_W=2 with 4 words and no in_last -> full=1, in_ready=0.
- rst_n low mid-stream -> all outputs return to their reset values immediately.
